// File: rtl/alu_mul_seq_if.sv
// Handshake and ALU-side signal bundle for the sequential shift-and-add multiplier.
// The slave modport is the multiplier itself; the master modport is everything
// around it: the controller issuing requests and the shared combinational adder.
interface alu_mul_seq_if #(
    parameter int WIDTH = 8
);
    // Controller request/response
    logic                   start;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    // Shared ALU adder operands and result
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic                   alu_cin;
    logic [WIDTH-1:0]       alu_sum;
    logic                   alu_cout;

    modport master (
        output start,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  product,
        input  alu_a,
        input  alu_b,
        input  alu_cin,
        output alu_sum,
        output alu_cout
    );

    modport slave (
        input  start,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output product,
        output alu_a,
        output alu_b,
        output alu_cin,
        input  alu_sum,
        input  alu_cout
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier. It borrows the
// datapath's existing combinational adder: each RUN cycle it presents the upper
// half of the accumulator and either the multiplicand or zero, then captures the
// 9-bit sum (carry included) shifted right by one together with the lower half.
// WIDTH iterations yield a 2*WIDTH product. Only WIDTH = 8 is verified.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_mul_seq_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       m_q;
    logic [WIDTH-1:0]       acc_hi_q;
    logic [WIDTH-1:0]       acc_lo_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     product_q;

    logic [2*WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]       alu_a_d;
    logic [WIDTH-1:0]       alu_b_d;

    // Next accumulator: {cout, sum, acc_lo} shifted right by one, low 2*WIDTH bits.
    // The multiplier bit just consumed (acc_lo[0]) falls off the bottom.
    always_comb begin
        acc_d = {bus.alu_cout, bus.alu_sum, acc_lo_q[WIDTH-1:1]};
    end

    // Adder operands: only meaningful while iterating, parked at zero otherwise.
    always_comb begin
        alu_a_d = '0;
        alu_b_d = '0;
        if (state_q == S_RUN) begin
            alu_a_d = acc_hi_q;
            alu_b_d = acc_lo_q[0] ? m_q : '0;
        end
    end

    assign bus.alu_a   = alu_a_d;
    assign bus.alu_b   = alu_b_d;
    assign bus.alu_cin = 1'b0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    // Control FSM and datapath registers; busy/done are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE, giving
                // back-to-back operation when start is held.
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q      <= bus.op_a;
                        acc_hi_q <= '0;
                        acc_lo_q <= bus.op_b;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end

                // One add-and-shift per cycle; start is ignored here.
                S_RUN: begin
                    acc_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                    acc_lo_q <= acc_d[WIDTH-1:0];
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared adder.
module tb_alu_mul_seq;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Observations gathered while waiting for a result
    logic       saw_cout;
    logic       alu_b_nz;
    logic       cin_seen;
    logic       prod_changed;
    logic [15:0] prev_prod;

    alu_mul_seq_if #(.WIDTH(8)) bus ();

    alu_mul_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External combinational 8-bit adder with carry out
    assign {bus.alu_cout, bus.alu_sum} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'b0, bus.alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick until done (bounded); returns ticks taken and busy samples seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat          = 0;
        busy_n       = 0;
        saw_cout     = 1'b0;
        alu_b_nz     = 1'b0;
        cin_seen     = 1'b0;
        prod_changed = 1'b0;
        prev_prod    = bus.product;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.alu_cout === 1'b1) saw_cout = 1'b1;
            if (bus.alu_b !== 8'h00) alu_b_nz = 1'b1;
            if (bus.alu_cin !== 1'b0) cin_seen = 1'b1;
            if (bus.product !== prev_prod) prod_changed = 1'b1;
            tick();
            lat++;
        end
    endtask

    // One full multiply with latency, busy width, result, hold and pulse checks.
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
        int lat;
        int bn;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        tick();
        bus.start = 1'b0;
        bus.op_a  = $urandom_range(0, 255);
        bus.op_b  = $urandom_range(0, 255);
        wait_done(lat, bn);
        check({tag, " latency"}, lat, 8);
        check({tag, " busy_cycles"}, bn, 8);
        check({tag, " product"}, bus.product, exp);
        check({tag, " hold_during_run"}, prod_changed, 1'b0);
        check({tag, " cin"}, cin_seen, 1'b0);
        tick();
        check({tag, " done_pulse"}, bus.done, 1'b0);
        check({tag, " product_held"}, bus.product, exp);
        $display("[TB] %s: %0d * %0d -> %04h (expected %04h)", tag, a, b, bus.product, exp);
    endtask

    initial begin
        int lat;
        int bn;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [15:0] rexp;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = 8'h00;
        bus.op_b  = 8'h00;

        // Reset values, before any clock edge
        #2;
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst product", bus.product, 16'h0000);
        check("rst alu_a", bus.alu_a, 8'h00);
        check("rst alu_b", bus.alu_b, 8'h00);
        check("rst alu_cin", bus.alu_cin, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle busy", bus.busy, 1'b0);

        // Basic products
        do_mul(8'd10, 8'd20, 16'h00C8, "10x20");
        do_mul(8'd0, 8'd77, 16'h0000, "0x77");
        check("0x77 alu_b_zero", alu_b_nz, 1'b0);
        do_mul(8'd255, 8'd255, 16'hFE01, "255x255");
        check("255x255 carry_seen", saw_cout, 1'b1);
        do_mul(8'd1, 8'd255, 16'h00FF, "1x255");

        // Start while busy is ignored
        bus.start = 1'b1;
        bus.op_a  = 8'd3;
        bus.op_b  = 8'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.op_a  = 8'd9;
        bus.op_b  = 8'd9;
        tick();
        bus.start = 1'b0;
        check("ignored busy", bus.busy, 1'b1);
        wait_done(lat, bn);
        check("3x5 latency_rest", lat, 5);
        check("3x5 product", bus.product, 16'h000F);
        $display("[TB] 3x5 with ignored 9x9: product %04h", bus.product);

        // Back-to-back: start during the DONE cycle
        bus.start = 1'b1;
        bus.op_a  = 8'd7;
        bus.op_b  = 8'd6;
        tick();
        bus.start = 1'b0;
        check("b2b busy", bus.busy, 1'b1);
        check("b2b done_low", bus.done, 1'b0);
        wait_done(lat, bn);
        check("b2b period", lat + 1, 9);
        check("b2b product", bus.product, 16'h002A);
        check("b2b hold", prod_changed, 1'b0);
        $display("[TB] 7x6 back-to-back: product %04h after %0d cycles", bus.product, lat + 1);
        tick();

        // Asynchronous reset mid-run
        bus.start = 1'b1;
        bus.op_a  = 8'd200;
        bus.op_b  = 8'd100;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst product", bus.product, 16'h0000);
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        check("midrst alu_a", bus.alu_a, 8'h00);
        check("midrst alu_b", bus.alu_b, 8'h00);
        check("midrst alu_cin", bus.alu_cin, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            tick();
            check("midrst no_done", bus.done, 1'b0);
        end
        check("midrst idle_busy", bus.busy, 1'b0);
        $display("[TB] reset mid-run: product %04h busy %0b", bus.product, bus.busy);
        do_mul(8'd12, 8'd12, 16'h0090, "12x12");

        // Random pairs against a*b
        for (int k = 0; k < 200; k++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rexp = 16'(ra) * 16'(rb);
            do_mul(ra, rb, rexp, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
